dds_sweep_controller: RTL and testbench

// Frequency-hop/sweep sequencer for dds_multichannel. Holds a table of up to TABLE_DEPTH

---
 rtl/dds_sweep_controller_if.sv | 22 ++
 rtl/dds_sweep_controller.sv | 185 ++++++++++++++++++
 tb/tb_dds_sweep_controller.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_controller_if.sv
// ============================================================================
// Module      : dds_sweep_controller_if
// Description : AXI-Stream style valid/ready/data bundle carrying one
//               phase-increment word per transfer.
//               master : drives valid/data, samples ready
//               slave  : samples valid/data, drives ready
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dds_sweep_controller_if #(
    parameter int DWIDTH = 48
) ();
    logic              valid;
    logic              ready;
    logic [DWIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/dds_sweep_controller.sv
// ============================================================================
// Module      : dds_sweep_controller
// Description : Frequency-hop/sweep sequencer. Holds a table of TABLE_DEPTH
//               entries, each CHANNELS lanes of PHASE_BITS phase increment,
//               and steps through the first N entries presenting each on an
//               AXI-Stream master port, holding each entry for a programmable
//               dwell (counted from the handshake). Runs once or loops.
// Ports       : clk, reset_n (sync, active low)
//               cfg_valid/cfg_ready/cfg_addr/cfg_channel/cfg_data : table write
//               start/stop, num_entries/dwell_cycles/loop_en      : run control
//               phase_inc_out (master)  : lane c = data[c*PHASE_BITS +: PHASE_BITS]
//               busy, done, entry_idx   : status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_sweep_controller #(
    parameter int PHASE_BITS  = 24,
    parameter int CHANNELS    = 2,
    parameter int TABLE_DEPTH = 16,
    parameter int DWELL_BITS  = 32,
    localparam int AW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int NW = $clog2(TABLE_DEPTH + 1),
    localparam int DW = PHASE_BITS * CHANNELS
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  cfg_valid,
    output logic                       cfg_ready,
    input  wire logic [AW-1:0]         cfg_addr,
    input  wire logic [CW-1:0]         cfg_channel,
    input  wire logic [PHASE_BITS-1:0] cfg_data,
    input  wire logic                  start,
    input  wire logic                  stop,
    input  wire logic [NW-1:0]         num_entries,
    input  wire logic [DWELL_BITS-1:0] dwell_cycles,
    input  wire logic                  loop_en,
    dds_sweep_controller_if.master     phase_inc_out,
    output logic                       busy,
    output logic                       done,
    output logic [AW-1:0]              entry_idx
);

    localparam logic [NW-1:0]         C_DEPTH = NW'(TABLE_DEPTH);
    localparam logic [DWELL_BITS-1:0] C_ONE   = DWELL_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t                  r_state, w_state_next;
    logic [AW-1:0]           r_idx, w_idx_next;
    logic [AW-1:0]           r_last;
    logic [DWELL_BITS-1:0]   r_dwell, r_cnt, w_cnt_next;
    logic                    r_loop;
    logic                    r_done, w_done_next;
    logic                    w_load, w_start_acc, w_advance;
    logic [DW-1:0]           r_data, w_entry;
    logic [NW-1:0]           w_n;
    logic [DWELL_BITS-1:0]   w_dwell_eff;
    logic [PHASE_BITS-1:0]   r_table [TABLE_DEPTH][CHANNELS];

    // Run parameters captured at start: N clamped to the table size,
    // zero dwell treated as one cycle.
    assign w_n         = (num_entries > C_DEPTH) ? C_DEPTH : num_entries;
    assign w_dwell_eff = (dwell_cycles == '0) ? C_ONE : dwell_cycles;

    // Entry about to be presented; only consumed on the transition into ISSUE.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign w_entry[c*PHASE_BITS +: PHASE_BITS] = r_table[w_idx_next][c];
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        w_start_acc  = 1'b0;
        w_advance    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !stop && (num_entries != '0)) begin
                    w_start_acc  = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = S_ISSUE;
                    w_load       = 1'b1;
                end
            end
            S_ISSUE: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (phase_inc_out.ready) begin
                    // Dwell of one means the next entry follows back-to-back.
                    if (r_dwell == C_ONE) begin
                        w_advance = 1'b1;
                    end else begin
                        w_cnt_next   = r_dwell - C_ONE;
                        w_state_next = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == C_ONE) begin
                    w_advance = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // End of an entry's dwell: step, wrap, or finish.
        if (w_advance) begin
            if (r_idx == r_last) begin
                if (r_loop) begin
                    w_idx_next   = '0;
                    w_state_next = S_ISSUE;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end else begin
                w_idx_next   = r_idx + AW'(1);
                w_state_next = S_ISSUE;
                w_load       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_dwell <= C_ONE;
            r_cnt   <= '0;
            r_loop  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            for (int a = 0; a < TABLE_DEPTH; a++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_table[a][c] <= '0;
                end
            end
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            if (w_load) begin
                r_data <= w_entry;
            end
            if (w_start_acc) begin
                r_last  <= AW'(w_n - NW'(1));
                r_dwell <= w_dwell_eff;
                r_loop  <= loop_en;
            end
            // Out-of-range addresses/lanes are acknowledged but discarded.
            if (cfg_valid && cfg_ready &&
                (int'(cfg_addr) < TABLE_DEPTH) && (int'(cfg_channel) < CHANNELS)) begin
                r_table[cfg_addr][cfg_channel] <= cfg_data;
            end
        end
    end

    assign cfg_ready           = (r_state == S_IDLE);
    assign busy                = (r_state != S_IDLE);
    assign done                = r_done;
    assign entry_idx           = r_idx;
    assign phase_inc_out.valid = (r_state == S_ISSUE);
    assign phase_inc_out.data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_dds_sweep_controller.sv
// ============================================================================
// Module      : tb_dds_sweep_controller
// Description : Directed self-checking bench for dds_sweep_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_sweep_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_addr;
    logic [0:0]  cfg_channel;
    logic [23:0] cfg_data;
    logic        start;
    logic        stop;
    logic [4:0]  num_entries;
    logic [31:0] dwell_cycles;
    logic        loop_en;
    logic        busy;
    logic        done;
    logic [3:0]  entry_idx;

    int vectors     = 0;
    int miscompares = 0;

    logic [47:0] exp_e [16];

    dds_sweep_controller_if #(.DWIDTH(48)) axis ();

    dds_sweep_controller #(
        .PHASE_BITS (24),
        .CHANNELS   (2),
        .TABLE_DEPTH(16),
        .DWELL_BITS (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_channel  (cfg_channel),
        .cfg_data     (cfg_data),
        .start        (start),
        .stop         (stop),
        .num_entries  (num_entries),
        .dwell_cycles (dwell_cycles),
        .loop_en      (loop_en),
        .phase_inc_out(axis),
        .busy         (busy),
        .done         (done),
        .entry_idx    (entry_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int ch, input logic [23:0] d);
        cfg_valid   = 1'b1;
        cfg_addr    = 4'(addr);
        cfg_channel = 1'(ch);
        cfg_data    = d;
        step();
        cfg_valid   = 1'b0;
    endtask

    // Start pulse in cycle 0; returns positioned in cycle 1.
    task automatic start_seq(input int n, input int d, input logic lp);
        start        = 1'b1;
        num_entries  = 5'(n);
        dwell_cycles = 32'(d);
        loop_en      = lp;
        step();
        start        = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        vectors++;
        if (axis.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || entry_idx !== 4'd0 ||
            cfg_ready !== 1'b1 || axis.data !== 48'd0) begin
            miscompares++;
            $display("FAIL reset got valid=%b busy=%b done=%b idx=%0d ready=%b data=%h exp 0 0 0 0 1 0",
                     axis.valid, busy, done, entry_idx, cfg_ready, axis.data);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic load_first_three();
        cfg_write(0, 0, 24'h007C35); cfg_write(1, 0, 24'h14AE14); cfg_write(2, 0, 24'h0F0000);
        cfg_write(0, 1, 24'h001C3A); cfg_write(1, 1, 24'h00051A); cfg_write(2, 1, 24'h30F5C2);
    endtask

    task automatic test_single_run();
        logic ev;
        start_seq(3, 10, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            ev = (k == 1 || k == 11 || k == 21);
            vectors++;
            if (axis.valid !== ev || done !== (k == 31) || busy !== (k < 31)) begin
                miscompares++;
                $display("FAIL single cyc=%0d got valid=%b done=%b busy=%b exp %b %b %b",
                         k, axis.valid, done, busy, ev, (k == 31), (k < 31));
            end
            if (ev) begin
                vectors++;
                if (axis.data !== exp_e[(k-1)/10] || entry_idx !== 4'((k-1)/10)) begin
                    miscompares++;
                    $display("FAIL single_data cyc=%0d got %h idx=%0d exp %h idx=%0d",
                             k, axis.data, entry_idx, exp_e[(k-1)/10], (k-1)/10);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic        ev;
        logic [47:0] ed;
        start_seq(3, 10, 1'b0);
        for (int k = 1; k <= 37; k++) begin
            axis.ready = !(k >= 11 && k <= 15);
            ev = (k == 1) || (k >= 11 && k <= 16) || (k == 26);
            ed = (k == 1) ? exp_e[0] : (k == 26) ? exp_e[2] : exp_e[1];
            vectors++;
            if (axis.valid !== ev || done !== (k == 36) || busy !== (k < 36)) begin
                miscompares++;
                $display("FAIL backpressure cyc=%0d got valid=%b done=%b busy=%b exp %b %b %b",
                         k, axis.valid, done, busy, ev, (k == 36), (k < 36));
            end
            if (ev) begin
                vectors++;
                if (axis.data !== ed) begin
                    miscompares++;
                    $display("FAIL backpressure_data cyc=%0d got %h exp %h", k, axis.data, ed);
                end
            end
            step();
        end
        axis.ready = 1'b1;
    endtask

    task automatic test_loop_stop();
        start_seq(2, 1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            stop = (k == 8);
            vectors++;
            if (axis.valid !== (k <= 8) || busy !== (k <= 8) || done !== 1'b0) begin
                miscompares++;
                $display("FAIL loop_stop cyc=%0d got valid=%b busy=%b done=%b exp %b %b 0",
                         k, axis.valid, busy, done, (k <= 8), (k <= 8));
            end
            if (k <= 8) begin
                vectors++;
                if (axis.data !== exp_e[(k-1)%2] || entry_idx !== 4'((k-1)%2)) begin
                    miscompares++;
                    $display("FAIL loop_data cyc=%0d got %h idx=%0d exp %h idx=%0d",
                             k, axis.data, entry_idx, exp_e[(k-1)%2], (k-1)%2);
                end
            end
            step();
        end
        stop = 1'b0;
    endtask

    task automatic test_cfg_and_limits();
        for (int i = 3; i < 16; i++) begin
            cfg_write(i, 0, exp_e[i][23:0]);
            cfg_write(i, 1, exp_e[i][47:24]);
        end
        // Write attempt during a run must be refused.
        start_seq(3, 10, 1'b0);
        step(); step();
        vectors++;
        if (cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_ready_busy got %b exp 0", cfg_ready);
        end
        cfg_write(0, 0, 24'hABCDEF);
        repeat (35) step();
        // N=0 start is ignored.
        start = 1'b1; num_entries = 5'd0; dwell_cycles = 32'd1; loop_en = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (busy !== 1'b0 || axis.valid !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_start cyc=%0d got busy=%b valid=%b done=%b exp 0 0 0",
                         k, busy, axis.valid, done);
            end
            step();
        end
        // start together with stop: stop wins.
        start = 1'b1; stop = 1'b1; num_entries = 5'd3;
        step();
        start = 1'b0; stop = 1'b0;
        vectors++;
        if (busy !== 1'b0 || axis.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL start_stop got busy=%b valid=%b exp 0 0", busy, axis.valid);
        end
        step();
        // N beyond table depth clamps to all 16 entries.
        start_seq(20, 1, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            vectors++;
            if (axis.valid !== (k <= 16) || done !== (k == 17) || busy !== (k <= 16)) begin
                miscompares++;
                $display("FAIL clamp cyc=%0d got valid=%b done=%b busy=%b exp %b %b %b",
                         k, axis.valid, done, busy, (k <= 16), (k == 17), (k <= 16));
            end
            if (k <= 16) begin
                vectors++;
                if (axis.data !== exp_e[k-1] || entry_idx !== 4'(k-1)) begin
                    miscompares++;
                    $display("FAIL clamp_data cyc=%0d got %h idx=%0d exp %h idx=%0d",
                             k, axis.data, entry_idx, exp_e[k-1], k-1);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midrun();
        start_seq(3, 10, 1'b0);
        repeat (12) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        vectors++;
        if (axis.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || entry_idx !== 4'd0 ||
            cfg_ready !== 1'b1 || axis.data !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_midrun got valid=%b busy=%b done=%b idx=%0d ready=%b data=%h exp 0 0 0 0 1 0",
                     axis.valid, busy, done, entry_idx, cfg_ready, axis.data);
        end
        step();
        start_seq(3, 2, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            vectors++;
            if (axis.valid !== (k == 1 || k == 3 || k == 5) || done !== (k == 7)) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d got valid=%b done=%b exp %b %b",
                         k, axis.valid, done, (k == 1 || k == 3 || k == 5), (k == 7));
            end
            if (axis.valid === 1'b1) begin
                vectors++;
                if (axis.data !== 48'd0) begin
                    miscompares++;
                    $display("FAIL post_reset_data cyc=%0d got %h exp 0", k, axis.data);
                end
            end
            step();
        end
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_channel = '0; cfg_data = '0;
        start = 1'b0; stop = 1'b0; num_entries = '0; dwell_cycles = '0; loop_en = 1'b0;
        axis.ready = 1'b1;
        exp_e[0] = {24'h001C3A, 24'h007C35};
        exp_e[1] = {24'h00051A, 24'h14AE14};
        exp_e[2] = {24'h30F5C2, 24'h0F0000};
        for (int i = 3; i < 16; i++) begin
            exp_e[i] = {24'(32'h200000 + i), 24'(32'h100000 + i)};
        end

        test_reset();
        load_first_three();
        test_single_run();
        step();
        test_backpressure();
        step();
        test_loop_stop();
        step();
        test_cfg_and_limits();
        step();
        test_reset_midrun();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
